alu_flag_unit: RTL and testbench

- Execute-stage ALU that sits directly upstream of the processor status register.
- Computes a 16-bit result and the {C,Z,L,F,N} flag vector and presents a merged 5-bit flag word plus a write strobe to the status register.
- Single-cycle ops complete in one cycle; shifts and multiply are iterative and use a start/busy/done handshake toward the controller.

---
 rtl/alu_defs.sv | 16 +
 rtl/alu_flag_calc.sv | 31 +++
 rtl/alu_flag_unit.sv | 106 ++++++++++
 tb/tb_alu_flag_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// alu_defs: opcodes, flag bit positions, flag masks and FSM states shared by the ALU
package alu_defs;
  localparam int DW = 16;
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8, OP_LSH = 4'd9, OP_ASH = 4'd10, OP_MUL = 4'd11;
  localparam int FLAG_C = 4, FLAG_Z = 3, FLAG_L = 2, FLAG_F = 1, FLAG_N = 0;
  localparam logic [4:0] MASK_ARITH = 5'b10010, MASK_CMP = 5'b01101, MASK_NONE = 5'b00000;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic [4:0] flag_mask(input logic [3:0] op);
    return op <= OP_SUBC ? MASK_ARITH : op == OP_CMP ? MASK_CMP : MASK_NONE;
  endfunction
  function automatic logic writes_result(input logic [3:0] op);
    return op != OP_CMP && op <= OP_MUL;
  endfunction
endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: single-cycle ALU result, freshly computed flags and the per-opcode flag mask
module alu_flag_calc import alu_defs::*; (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] res,
  output logic [4:0]    flags,
  output logic [4:0]    mask
);
  logic          is_sub, cy;
  logic [DW:0]   sum;
  always_comb begin
    is_sub = op == OP_SUB || op == OP_SUBC;
    cy = (op == OP_ADDC || op == OP_SUBC) && cin;
    sum = is_sub ? {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cy} : {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cy};
    flags = '0;
    flags[FLAG_C] = sum[DW];
    // same operand signs (add) or differing signs (sub), with the result sign moving away from a
    flags[FLAG_F] = ((a[DW-1] ^ b[DW-1]) == is_sub) && (sum[DW-1] != a[DW-1]);
    flags[FLAG_Z] = a == b;
    flags[FLAG_L] = b > a;
    flags[FLAG_N] = $signed(b) > $signed(a);
    res = (op == OP_ADD || op == OP_ADDC || is_sub) ? sum[DW-1:0] :
          op == OP_AND ? a & b :
          op == OP_OR  ? a | b :
          op == OP_XOR ? a ^ b :
          op == OP_MOV ? b : '0;
    mask = flag_mask(op);
  end
endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: execute-stage ALU with iterative shift/multiply and merged status-register flags
module alu_flag_unit import alu_defs::*; #(
  parameter int WIDTH      = DW,
  parameter int MUL_CYCLES = DW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [4:0]       psr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [4:0]       flags_out,
  output logic             flags_we,
  output logic             illegal
);
  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, mc, mp, calc_res, first_sh, first_val, step;
  logic [4:0]       calc_flags, calc_mask, mag, iter_cnt, cnt, psr_q;
  logic             is_mul, go_left, arith, accept, is_shift_in, is_mul_in, go_run, last;
  alu_flag_calc u_calc (
    .op   (opcode),
    .a    (a_in),
    .b    (b_in),
    .cin  (psr_in[FLAG_C]),
    .res  (calc_res),
    .flags(calc_flags),
    .mask (calc_mask)
  );
  // the capture edge already performs the first shift/multiply iteration
  always_comb begin
    accept = state == ST_IDLE && start;
    is_shift_in = opcode == OP_LSH || opcode == OP_ASH;
    is_mul_in = opcode == OP_MUL;
    mag = b_in[4] ? -b_in[4:0] : b_in[4:0];
    first_sh = mag == '0 ? a_in :
               b_in[4] ? {opcode == OP_ASH && a_in[WIDTH-1], a_in[WIDTH-1:1]} : {a_in[WIDTH-2:0], 1'b0};
    first_val = is_mul_in ? (b_in[0] ? a_in : '0) : is_shift_in ? first_sh : calc_res;
    iter_cnt = is_mul_in ? 5'(MUL_CYCLES - 1) : (is_shift_in && mag != '0) ? mag - 5'd1 : '0;
    go_run = accept && iter_cnt != '0;
    step = is_mul ? acc + (mp[0] ? mc : '0) :
           go_left ? {acc[WIDTH-2:0], 1'b0} : {arith && acc[WIDTH-1], acc[WIDTH-1:1]};
    last = cnt == 5'd1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_nx;
  always_comb state_nx = state == ST_IDLE ? (go_run ? ST_RUN : ST_IDLE) : (last ? ST_IDLE : ST_RUN);
  always_comb busy = state == ST_RUN;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
      result_we <= 1'b0;
      flags_we <= 1'b0;
      illegal <= 1'b0;
      result <= '0;
      flags_out <= '0;
      acc <= '0;
      mc <= '0;
      mp <= '0;
      cnt <= '0;
      psr_q <= '0;
      is_mul <= 1'b0;
      go_left <= 1'b0;
      arith <= 1'b0;
    end else begin
      done <= 1'b0;
      result_we <= 1'b0;
      flags_we <= 1'b0;
      illegal <= 1'b0;
      if (accept) begin
        acc <= first_val;
        mc <= a_in << 1;
        mp <= b_in >> 1;
        cnt <= iter_cnt;
        is_mul <= is_mul_in;
        go_left <= !b_in[4];
        arith <= opcode == OP_ASH;
        psr_q <= psr_in;
        if (!go_run) begin
          done <= 1'b1;
          result_we <= writes_result(opcode);
          flags_we <= |calc_mask;
          illegal <= opcode > OP_MUL;
          flags_out <= (psr_in & ~calc_mask) | (calc_flags & calc_mask);
          if (writes_result(opcode)) result <= first_val;
        end
      end else if (busy) begin
        acc <= step;
        mc <= mc << 1;
        mp <= mp >> 1;
        cnt <= cnt - 5'd1;
        if (last) begin
          done <= 1'b1;
          result_we <= 1'b1;
          result <= step;
          flags_out <= psr_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_flag_unit.sv
// tb_alu_flag_unit: directed and random ALU ops checked against a behavioural scoreboard model
module tb_alu_flag_unit;
  import alu_defs::*;
  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [4:0]  psr_in = '0;
  logic        busy, done, result_we, flags_we, illegal;
  logic [15:0] result;
  logic [4:0]  flags_out;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    int          op;
    logic [15:0] res;
    logic        rwe, fwe, ill;
    logic [4:0]  fl;
    int          cyc;
  } exp_t;
  exp_t        sbq[$];
  logic [15:0] mres = '0;
  alu_flag_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .psr_in(psr_in), .busy(busy), .done(done), .result(result), .result_we(result_we),
    .flags_out(flags_out), .flags_we(flags_we), .illegal(illegal)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] psr, input int now);
    exp_t e;
    int c, s, sa, sb, n;
    logic [15:0] r;
    logic [4:0] sh;
    c = int'(psr[4]);
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    r = mres;
    e.op = int'(op);
    e.rwe = 1'b0;
    e.fwe = 1'b0;
    e.ill = 1'b0;
    e.fl = psr;
    e.cyc = now + 1;
    case (op)
      OP_ADD, OP_ADDC: begin
        s = int'(a) + int'(b) + (op == OP_ADDC ? c : 0);
        r = s[15:0];
        e.fl[4] = s > 65535;
        s = sa + sb + (op == OP_ADDC ? c : 0);
        e.fl[1] = s > 32767 || s < -32768;
        e.rwe = 1'b1;
        e.fwe = 1'b1;
      end
      OP_SUB, OP_SUBC: begin
        s = int'(a) - int'(b) - (op == OP_SUBC ? c : 0);
        r = s[15:0];
        e.fl[4] = s < 0;
        s = sa - sb - (op == OP_SUBC ? c : 0);
        e.fl[1] = s > 32767 || s < -32768;
        e.rwe = 1'b1;
        e.fwe = 1'b1;
      end
      OP_CMP: begin
        e.fl[3] = a == b;
        e.fl[2] = b > a;
        e.fl[0] = sb > sa;
        e.fwe = 1'b1;
      end
      OP_AND: begin r = a & b; e.rwe = 1'b1; end
      OP_OR:  begin r = a | b; e.rwe = 1'b1; end
      OP_XOR: begin r = a ^ b; e.rwe = 1'b1; end
      OP_MOV: begin r = b; e.rwe = 1'b1; end
      OP_LSH, OP_ASH: begin
        n = sh[4] ? 32 - int'(sh) : int'(sh);
        if (!sh[4]) r = a << n;
        else if (op == OP_ASH) r = $signed(a) >>> n;
        else r = a >> n;
        e.cyc = now + (n == 0 ? 1 : n);
        e.rwe = 1'b1;
      end
      OP_MUL: begin r = a * b; e.cyc = now + 16; e.rwe = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.rwe) mres = r;
    e.res = mres;
    return e;
  endfunction
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [4:0] psr);
    int w = 0;
    while (busy && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (busy) chk("issue_wait", busy, 0);
    start = 1'b1;
    opcode = op;
    a_in = a;
    b_in = b;
    psr_in = psr;
    sbq.push_back(model(op, a, b, psr, cyc));
    @(negedge clock);
    start = 1'b0;
    opcode = 4'($urandom);
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    psr_in = 5'($urandom);
  endtask
  task automatic drain();
    int w = 0;
    while ((busy || sbq.size() != 0) && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("drain", sbq.size(), 0);
  endtask
  always @(negedge clock)
    if (reset_n && done) begin
      if (sbq.size() == 0) chk("spurious_done", done, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("op%0d_result", e.op), result, e.res);
        chk($sformatf("op%0d_result_we", e.op), result_we, e.rwe);
        chk($sformatf("op%0d_flags_out", e.op), flags_out, e.fl);
        chk($sformatf("op%0d_flags_we", e.op), flags_we, e.fwe);
        chk($sformatf("op%0d_illegal", e.op), illegal, e.ill);
        chk($sformatf("op%0d_done_cycle", e.op), cyc, e.cyc);
      end
    end
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_we", {result_we, flags_we, illegal}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    issue(OP_ADD, 16'h7FFF, 16'h0001, 5'b00000);
    issue(OP_ADDC, 16'hFFFF, 16'h0000, 5'b10101);
    issue(OP_CMP, 16'h0005, 16'hFFFF, 5'b10000);
    issue(OP_MUL, 16'h0123, 16'h0010, 5'b01010);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("mul_busy_t%0d", i), busy, 1);
      start = i == 5;
      opcode = OP_ADD;
      @(negedge clock);
    end
    start = 1'b0;
    chk("mul_idle_t16", busy, 0);
    issue(OP_ASH, 16'h8000, 16'h001D, 5'b00000);
    issue(OP_LSH, 16'h8000, 16'h001D, 5'b00000);
    issue(OP_LSH, 16'hABCD, 16'h0010, 5'b11111);
    issue(OP_ASH, 16'h8001, 16'h0010, 5'b00000);
    issue(OP_ASH, 16'h7FFF, 16'h0010, 5'b00000);
    issue(OP_LSH, 16'h1234, 16'h0000, 5'b00000);
    issue(OP_LSH, 16'h0003, 16'h000F, 5'b00000);
    issue(OP_ASH, 16'hC001, 16'h001F, 5'b00000);
    issue(OP_SUB, 16'h0000, 16'h0001, 5'b00000);
    issue(OP_SUBC, 16'h8000, 16'h0000, 5'b10000);
    issue(OP_AND, 16'hF0F0, 16'h3C3C, 5'b11111);
    issue(OP_OR, 16'hF0F0, 16'h3C3C, 5'b00000);
    issue(OP_XOR, 16'hF0F0, 16'h3C3C, 5'b00000);
    issue(OP_MOV, 16'h0000, 16'hBEEF, 5'b00000);
    issue(4'd12, 16'h1111, 16'h2222, 5'b01011);
    issue(4'd15, 16'h1111, 16'h2222, 5'b10100);
    issue(OP_CMP, 16'h8000, 16'h8000, 5'b00000);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 5'b00000);
    for (int i = 0; i < 24; i++)
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 5'($urandom));
    drain();
    issue(OP_MUL, 16'h4321, 16'h0007, 5'b00000);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    sbq.delete();
    mres = '0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("postrst_busy", busy, 0);
    issue(4'd13, 16'h5555, 16'hAAAA, 5'b10101);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
